// File: rtl/matmul_pkg.sv
// Shared state encoding and mode-bit positions for the matmul_ext engine.
package matmul_pkg;

  typedef enum logic [3:0] {
    IDLE, START, RD_C, WT_C, RD_A, WT_A, RD_B, WT_B, WR_C, DONE
  } state_e;

  localparam int unsigned MODE_ACCUM   = 0;
  localparam int unsigned MODE_SIGNED  = 1;
  localparam int unsigned MODE_TRANS_B = 2;

endpackage

// File: rtl/matmul_ext_mac.sv
// Extend-multiply-accumulate: acc + ext(a)*ext(b), wrapping at MEM_DW bits.
module matmul_mac #(
  parameter int unsigned PREC   = 16,
  parameter int unsigned MEM_DW = 32
) (
  input  logic              signed_i,
  input  logic [PREC-1:0]   a_i,
  input  logic [PREC-1:0]   b_i,
  input  logic [MEM_DW-1:0] acc_i,
  output logic [MEM_DW-1:0] sum_o
);

  logic [MEM_DW-1:0] a_ext, b_ext;

  // Low MEM_DW bits of the product are identical for signed and unsigned
  // once the operands are extended to full width.
  always_comb begin
    a_ext = {{(MEM_DW-PREC){signed_i & a_i[PREC-1]}}, a_i};
    b_ext = {{(MEM_DW-PREC){signed_i & b_i[PREC-1]}}, b_i};
    sum_o = acc_i + a_ext * b_ext;
  end

endmodule

// File: rtl/matmul_ext.sv
// Memory-mastering matrix multiply engine: C = A*B or C += A*B, with signed
// or unsigned operands and optional transposed-B addressing.
module matmul_ext
  import matmul_pkg::*;
#(
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned MEM_DW   = 32,
  parameter int unsigned DIM_BITS = 16,
  parameter int unsigned PREC     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sm_ena,
  input  logic                go,
  input  logic [2:0]          mode,
  input  logic [MEM_AW-1:0]   aBASE,
  input  logic [MEM_AW-1:0]   bBASE,
  input  logic [MEM_AW-1:0]   cBASE,
  input  logic [DIM_BITS-1:0] aSTRIDE,
  input  logic [DIM_BITS-1:0] bSTRIDE,
  input  logic [DIM_BITS-1:0] cSTRIDE,
  input  logic [DIM_BITS-1:0] aROWS,
  input  logic [DIM_BITS-1:0] aCOLS,
  input  logic [DIM_BITS-1:0] bCOLS,
  output logic                ret,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_rdata_vld,
  input  logic [MEM_DW-1:0]   mem_rdata
);

  state_e              state_q, state_d;
  logic                accum_q, accum_d, sgn_q, sgn_d;
  logic [DIM_BITS-1:0] arows_q, arows_d, acols_q, acols_d, bcols_q, bcols_d;
  logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MEM_AW-1:0]   astr_q, astr_d, cstr_q, cstr_d, bk_q, bk_d, bj_q, bj_d;
  logic [MEM_AW-1:0]   bbase_q, bbase_d, a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [MEM_AW-1:0]   b_col_q, b_col_d, b_ptr_q, b_ptr_d, c_row_q, c_row_d;
  logic [MEM_AW-1:0]   c_ptr_q, c_ptr_d;
  logic [MEM_DW-1:0]   acc_q, acc_d, hold_data_q, hold_data_d, rdata_eff, mac_sum;
  logic [PREC-1:0]     a_q, a_d;
  logic                hold_vld_q, hold_vld_d, vld_eff, wt_state;
  logic                last_i, last_j, last_k;

  assign wt_state  = (state_q == WT_C) || (state_q == WT_A) || (state_q == WT_B);
  assign vld_eff   = hold_vld_q | mem_rdata_vld;
  assign rdata_eff = hold_vld_q ? hold_data_q : mem_rdata;
  assign last_i    = (i_q == arows_q - DIM_BITS'(1));
  assign last_j    = (j_q == bcols_q - DIM_BITS'(1));
  assign last_k    = (k_q == acols_q - DIM_BITS'(1));

  matmul_mac #(.PREC(PREC), .MEM_DW(MEM_DW)) u_mac (
    .signed_i (sgn_q),
    .a_i      (a_q),
    .b_i      (rdata_eff[PREC-1:0]),
    .acc_i    (acc_q),
    .sum_o    (mac_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      accum_q <= 1'b0;      sgn_q   <= 1'b0;
      arows_q <= '0;        acols_q <= '0;       bcols_q <= '0;
      i_q     <= '0;        j_q     <= '0;       k_q     <= '0;
      astr_q  <= '0;        cstr_q  <= '0;       bk_q    <= '0;       bj_q  <= '0;
      bbase_q <= '0;        a_row_q <= '0;       a_ptr_q <= '0;
      b_col_q <= '0;        b_ptr_q <= '0;       c_row_q <= '0;       c_ptr_q <= '0;
      acc_q   <= '0;        a_q     <= '0;
      hold_vld_q <= 1'b0;   hold_data_q <= '0;
    end else begin
      state_q <= state_d;
      accum_q <= accum_d;   sgn_q   <= sgn_d;
      arows_q <= arows_d;   acols_q <= acols_d;  bcols_q <= bcols_d;
      i_q     <= i_d;       j_q     <= j_d;      k_q     <= k_d;
      astr_q  <= astr_d;    cstr_q  <= cstr_d;   bk_q    <= bk_d;     bj_q  <= bj_d;
      bbase_q <= bbase_d;   a_row_q <= a_row_d;  a_ptr_q <= a_ptr_d;
      b_col_q <= b_col_d;   b_ptr_q <= b_ptr_d;  c_row_q <= c_row_d;  c_ptr_q <= c_ptr_d;
      acc_q   <= acc_d;     a_q     <= a_d;
      hold_vld_q <= hold_vld_d; hold_data_q <= hold_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accum_d = accum_q;  sgn_d   = sgn_q;
    arows_d = arows_q;  acols_d = acols_q;  bcols_d = bcols_q;
    i_d     = i_q;      j_d     = j_q;      k_d     = k_q;
    astr_d  = astr_q;   cstr_d  = cstr_q;   bk_d    = bk_q;     bj_d = bj_q;
    bbase_d = bbase_q;  a_row_d = a_row_q;  a_ptr_d = a_ptr_q;
    b_col_d = b_col_q;  b_ptr_d = b_ptr_q;  c_row_d = c_row_q;  c_ptr_d = c_ptr_q;
    acc_d   = acc_q;    a_d     = a_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;

    if (!sm_ena) begin
      // Park read data that lands during a stall; consumed once sm_ena returns.
      if (wt_state && mem_rdata_vld && !hold_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_data_d = mem_rdata;
      end
    end else begin
      hold_vld_d = 1'b0;
      unique case (state_q)
        IDLE: if (go) begin
          accum_d = mode[MODE_ACCUM];
          sgn_d   = mode[MODE_SIGNED];
          arows_d = aROWS;  acols_d = aCOLS;  bcols_d = bCOLS;
          astr_d  = MEM_AW'(aSTRIDE);
          cstr_d  = MEM_AW'(cSTRIDE);
          bk_d    = mode[MODE_TRANS_B] ? MEM_AW'(1) : MEM_AW'(bSTRIDE);
          bj_d    = mode[MODE_TRANS_B] ? MEM_AW'(bSTRIDE) : MEM_AW'(1);
          bbase_d = bBASE;
          a_row_d = aBASE;  a_ptr_d = aBASE;
          b_col_d = bBASE;  b_ptr_d = bBASE;
          c_row_d = cBASE;  c_ptr_d = cBASE;
          i_d = '0;  j_d = '0;  k_d = '0;
          state_d = START;
        end
        START: begin
          if (arows_q == '0 || acols_q == '0 || bcols_q == '0) state_d = DONE;
          else if (accum_q) state_d = RD_C;
          else begin
            acc_d   = '0;
            state_d = RD_A;
          end
        end
        RD_C: state_d = WT_C;
        WT_C: if (vld_eff) begin
          acc_d   = rdata_eff;
          state_d = RD_A;
        end
        RD_A: state_d = WT_A;
        WT_A: if (vld_eff) begin
          a_d     = rdata_eff[PREC-1:0];
          state_d = RD_B;
        end
        RD_B: state_d = WT_B;
        WT_B: if (vld_eff) begin
          acc_d = mac_sum;
          if (last_k) state_d = WR_C;
          else begin
            k_d     = k_q + DIM_BITS'(1);
            a_ptr_d = a_ptr_q + MEM_AW'(1);
            b_ptr_d = b_ptr_q + bk_q;
            state_d = RD_A;
          end
        end
        WR_C: begin
          // Pointers for the next element are derived from the updated row/column bases.
          k_d = '0;
          if (last_j && last_i) state_d = DONE;
          else begin
            if (last_j) begin
              j_d     = '0;
              i_d     = i_q + DIM_BITS'(1);
              a_row_d = a_row_q + astr_q;
              c_row_d = c_row_q + cstr_q;
              c_ptr_d = c_row_d;
              b_col_d = bbase_q;
            end else begin
              j_d     = j_q + DIM_BITS'(1);
              c_ptr_d = c_ptr_q + MEM_AW'(1);
              b_col_d = b_col_q + bj_q;
            end
            a_ptr_d = a_row_d;
            b_ptr_d = b_col_d;
            if (accum_q) state_d = RD_C;
            else begin
              acc_d   = '0;
              state_d = RD_A;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign ret       = sm_ena && (state_q == DONE);
  assign mem_req   = sm_ena && ((state_q == RD_C) || (state_q == RD_A) ||
                                (state_q == RD_B) || (state_q == WR_C));
  assign mem_write = sm_ena && (state_q == WR_C);
  assign mem_wdata = acc_q;

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      RD_C, WR_C: mem_addr = c_ptr_q;
      RD_A:       mem_addr = a_ptr_q;
      RD_B:       mem_addr = b_ptr_q;
      default:    mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_matmul_ext.sv
// Directed bench for matmul_ext against a 1-cycle word memory model.
module tb_matmul_ext;

  logic        clk = 1'b0, rst = 1'b1, sm_ena = 1'b1, go = 1'b0;
  logic [2:0]  mode = '0;
  logic [15:0] aBASE = '0, bBASE = '0, cBASE = '0;
  logic [15:0] aSTRIDE = '0, bSTRIDE = '0, cSTRIDE = '0;
  logic [15:0] aROWS = '0, aCOLS = '0, bCOLS = '0;
  logic        ret, busy, mem_req, mem_write, rvld;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, rdata;

  logic [31:0] mem [0:65535];
  logic        pl_en = 1'b0, clr = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          cyc = 0, n_req = 0, first_req = -1, ret_cyc = -1, go_cyc = -1;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  matmul_ext #(.MEM_AW(16), .MEM_DW(32), .DIM_BITS(16), .PREC(16)) dut (
    .clk(clk), .rst(rst), .sm_ena(sm_ena), .go(go), .mode(mode),
    .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE),
    .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE), .cSTRIDE(cSTRIDE),
    .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS),
    .ret(ret), .busy(busy), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(rvld), .mem_rdata(rdata)
  );

  // Memory model: read data valid exactly one cycle after the request.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rvld <= 1'b0;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (clr) begin
      n_req <= 0; first_req <= -1; ret_cyc <= -1; go_cyc <= -1;
    end else begin
      if (mem_req) begin
        n_req <= n_req + 1;
        if (first_req < 0) first_req <= cyc;
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else begin
          rvld  <= 1'b1;
          rdata <= mem[mem_addr];
        end
      end
      if (ret) ret_cyc <= cyc;
      if (go && !busy && sm_ena && !rst) go_cyc <= cyc;
    end
  end

  typedef struct {
    logic [2:0] mode;
    int         bstr;
    bit         fill;
    bit         stall;
    int         lat;
    int         reqs;
  } scn_t;

  scn_t scn [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Region 0=A, 1=B, 2=C; contents depend only on the word offset in the region.
  function automatic logic [31:0] memval(input int region, input int off, input bit fill);
    case (region)
      0:       return fill ? 32'hABCD_FFFF : 32'(off + 1);
      1:       return fill ? 32'h1234_0003 : 32'(off * 3 + 2);
      default: return 32'(1000 + off);
    endcase
  endfunction

  function automatic logic [31:0] model_c(input scn_t s, input int i, input int j);
    logic [31:0] acc, w, ea, eb;
    logic [15:0] aw, bw;
    acc = s.mode[0] ? memval(2, i * 8 + j, s.fill) : 32'd0;
    for (int k = 0; k < 4; k++) begin
      w  = memval(0, i * 4 + k, s.fill);
      aw = w[15:0];
      w  = memval(1, s.mode[2] ? (j * s.bstr + k) : (k * s.bstr + j), s.fill);
      bw = w[15:0];
      ea = s.mode[1] ? {{16{aw[15]}}, aw} : {16'd0, aw};
      eb = s.mode[1] ? {{16{bw[15]}}, bw} : {16'd0, bw};
      acc = acc + ea * eb;
    end
    return acc;
  endfunction

  task automatic pl(input int a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = 16'(a); pl_data = d;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic preload(input bit fill);
    for (int o = 0; o < 24; o++) pl(16'h100 + o, memval(0, o, fill));
    for (int o = 0; o < 20; o++) pl(16'h200 + o, memval(1, o, fill));
    for (int o = 0; o < 48; o++) pl(16'h300 + o, memval(2, o, fill));
  endtask

  task automatic clear_stats();
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic set_cfg(input logic [2:0] m, input int bstr);
    mode = m; aBASE = 16'h100; bBASE = 16'h200; cBASE = 16'h300;
    aSTRIDE = 16'd4; bSTRIDE = 16'(bstr); cSTRIDE = 16'd8;
    aROWS = 16'd6; aCOLS = 16'd4; bCOLS = 16'd5;
  endtask

  task automatic pulse_go();
    go = 1'b1; @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic wait_ret(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!ret && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_ret_seen"}, {31'd0, ret}, 32'd1);
    check({nm, "_busy_at_ret"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({nm, "_ret_one_cycle"}, {31'd0, ret}, 32'd0);
    check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_scn(input int idx);
    string nm;
    int    t;
    nm = $sformatf("scn%0d", idx);
    preload(scn[idx].fill);
    set_cfg(scn[idx].mode, scn[idx].bstr);
    clear_stats();
    pulse_go();
    // Config and go changes while busy must have no effect.
    aBASE = 16'h0F00; bBASE = 16'h0E00; cBASE = 16'h0D00; mode = ~mode;
    aROWS = 16'd1; aCOLS = 16'd9; bSTRIDE = 16'd77;
    go = 1'b1; repeat (3) @(posedge clk); #1 go = 1'b0;
    if (scn[idx].stall) begin
      repeat (40) @(negedge clk);
      t = 0;
      while (!(mem_req && !mem_write) && t < 100) begin
        @(negedge clk);
        t++;
      end
      check({nm, "_stall_sync"}, {31'd0, mem_req && !mem_write}, 32'd1);
      @(posedge clk); #1 sm_ena = 1'b0;
      repeat (20) @(posedge clk);
      #1 sm_ena = 1'b1;
    end
    wait_ret(nm);
    check({nm, "_first_req_lat"}, 32'(first_req - go_cyc), 32'd2);
    check({nm, "_ret_lat"}, 32'(ret_cyc - first_req), 32'(scn[idx].lat));
    check({nm, "_req_count"}, 32'(n_req), 32'(scn[idx].reqs));
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5; j++)
        check($sformatf("%s_C%0d%0d", nm, i, j), mem[16'h300 + i * 8 + j], model_c(scn[idx], i, j));
  endtask

  initial begin
    scn[0] = '{3'b000, 5, 1'b0, 1'b0, 510, 270};
    scn[1] = '{3'b001, 5, 1'b0, 1'b0, 570, 300};
    scn[2] = '{3'b010, 5, 1'b1, 1'b0, 510, 270};
    scn[3] = '{3'b100, 4, 1'b0, 1'b0, 510, 270};
    scn[4] = '{3'b000, 5, 1'b0, 1'b1, 530, 270};
    scn[5] = '{3'b000, 5, 1'b1, 1'b0, 510, 270};
    scn[6] = '{3'b111, 4, 1'b0, 1'b0, 570, 300};

    #3;
    check("rst_ret", {31'd0, ret}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_write", {31'd0, mem_write}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    for (int s = 0; s < 7; s++) begin
      run_scn(s);
      if (scn[s].fill && scn[s].mode == 3'b010)
        check("signed_neg12", mem[16'h300], 32'hFFFF_FFF4);
    end

    // Any zero dimension: ret two cycles after go, no memory traffic.
    for (int d = 0; d < 3; d++) begin
      set_cfg(3'b001, 5);
      if (d == 0) aROWS = '0;
      else if (d == 1) aCOLS = '0;
      else bCOLS = '0;
      clear_stats();
      pulse_go();
      wait_ret($sformatf("zero%0d", d));
      check($sformatf("zero%0d_ret_lat", d), 32'(ret_cyc - go_cyc), 32'd2);
      check($sformatf("zero%0d_reqs", d), 32'(n_req), 32'd0);
    end

    // Reset mid-run just after a read request, so its data lands in IDLE.
    preload(1'b0);
    set_cfg(3'b001, 5);
    clear_stats();
    pulse_go();
    repeat (100) @(negedge clk);
    while (!(mem_req && !mem_write)) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ret", {31'd0, ret}, 32'd0);
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_addr", {16'd0, mem_addr}, 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("postrst_idle", {31'd0, busy}, 32'd0);
    run_scn(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
